// File: rtl/draw_ball.sv
// Square ball sprite rasteriser: scans a SIZE x SIZE block row-major from a
// latched top-left corner, clipping pixels outside the 160x120 visible area.
module draw_ball #(
  parameter int unsigned SIZE = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] ballX,
  input  logic [6:0] ballY,
  input  logic [2:0] colourIn,
  output logic [7:0] drawX,
  output logic [6:0] drawY,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST = 3'(SIZE - 1);

  state_t     state, nextState;
  logic [7:0] baseX;
  logic [6:0] baseY;
  logic [2:0] baseColour;
  logic [2:0] dx, dy;
  logic [8:0] sumX;
  logic [7:0] sumY;
  logic       lastCol, lastPixel;

  assign lastCol   = (dx == LAST);
  assign lastPixel = lastCol && (dy == LAST);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = DRAW;
      DRAW:    if (lastPixel) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  // Counters freeze on the final pixel so the outputs keep showing it
  // through DONE and IDLE without a separate holding register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      baseX      <= '0;
      baseY      <= '0;
      baseColour <= '0;
      dx         <= '0;
      dy         <= '0;
    end else if (state == IDLE && start) begin
      baseX      <= ballX;
      baseY      <= ballY;
      baseColour <= colourIn;
      dx         <= '0;
      dy         <= '0;
    end else if (state == DRAW && !lastPixel) begin
      if (lastCol) begin
        dx <= '0;
        dy <= dy + 3'd1;
      end else begin
        dx <= dx + 3'd1;
      end
    end
  end

  always_comb begin
    sumX   = {1'b0, baseX} + {6'b0, dx};
    sumY   = {1'b0, baseY} + {5'b0, dy};
    drawX  = sumX[7:0];
    drawY  = sumY[6:0];
    colour = baseColour;
    busy   = (state == DRAW);
    done   = (state == DONE);
    plot   = busy && (sumX <= 9'd159) && (sumY <= 8'd119);
  end

endmodule

// File: tb/tb_draw_ball.sv
// Bench for draw_ball: directed and randomised sprites compared against an
// arithmetic pixel model, plus a SIZE=1 instance.
module tb_draw_ball;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start, start1;
  logic [7:0] ballX, ballX1;
  logic [6:0] ballY, ballY1;
  logic [2:0] colourIn, colourIn1;
  logic [7:0] drawX, drawX1;
  logic [6:0] drawY, drawY1;
  logic [2:0] colour, colour1;
  logic       plot, busy, done, plot1, busy1, done1;

  int nAssert = 0;
  int nFail   = 0;

  draw_ball #(.SIZE(4)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .ballX(ballX), .ballY(ballY), .colourIn(colourIn),
    .drawX(drawX), .drawY(drawY), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  draw_ball #(.SIZE(1)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1),
    .ballX(ballX1), .ballY(ballY1), .colourIn(colourIn1),
    .drawX(drawX1), .drawY(drawY1), .colour(colour1),
    .plot(plot1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".drawX"}, 32'(drawX), 0);
    check({tag, ".drawY"}, 32'(drawY), 0);
    check({tag, ".colour"}, 32'(colour), 0);
    check({tag, ".plot"}, 32'(plot), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".drawX1"}, 32'(drawX1), 0);
    check({tag, ".plot1"}, 32'(plot1), 0);
    check({tag, ".busy1"}, 32'(busy1), 0);
    check({tag, ".done1"}, 32'(done1), 0);
  endtask

  // One SIZE=4 sprite; disturbAt (1..16, 0 = none) pulses start and scrambles
  // the inputs during that DRAW cycle, which must have no effect.
  task automatic runSprite(input int bx, input int by, input int c, input int disturbAt);
    int plots = 0;
    int expPlots = 0;
    int x, y;
    @(negedge clock);
    ballX = 8'(bx); ballY = 7'(by); colourIn = 3'(c); start = 1'b1;
    nextCycle();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k + 1 == disturbAt) begin
        start = 1'b1; ballX = 8'd50; ballY = ~ballY; colourIn = ~colourIn;
      end else if (k == disturbAt) begin
        start = 1'b0;
      end
      x = bx + k % 4;
      y = by + k / 4;
      check("draw.busy", 32'(busy), 1);
      check("draw.done", 32'(done), 0);
      check("draw.drawX", 32'(drawX), x % 256);
      check("draw.drawY", 32'(drawY), y % 128);
      check("draw.colour", 32'(colour), c);
      check("draw.plot", 32'(plot), (x <= 159 && y <= 119) ? 1 : 0);
      if (plot) plots++;
      if (x <= 159 && y <= 119) expPlots++;
      nextCycle();
    end
    start = 1'b0;
    check("done.done", 32'(done), 1);
    check("done.busy", 32'(busy), 0);
    check("done.plot", 32'(plot), 0);
    check("done.drawX", 32'(drawX), (bx + 3) % 256);
    check("done.drawY", 32'(drawY), (by + 3) % 128);
    nextCycle();
    check("idle.done", 32'(done), 0);
    check("idle.busy", 32'(busy), 0);
    check("idle.plot", 32'(plot), 0);
    check("idle.colour", 32'(colour), c);
    check("plotCount", 32'(plots), expPlots);
  endtask

  initial begin
    int ph;
    bit seen;
    resetn = 1'b0; start = 1'b0; start1 = 1'b0;
    ballX = '0; ballY = '0; colourIn = '0;
    ballX1 = '0; ballY1 = '0; colourIn1 = '0;
    #12;
    checkAllZero("reset");
    @(negedge clock);
    resetn = 1'b1;

    runSprite(10, 20, 3'b100, 0);
    runSprite(10, 20, 3'b100, 5);
    runSprite(158, 118, 3'b011, 0);
    runSprite(254, 126, 3'b111, 0);

    // Asynchronous reset mid-sprite
    @(negedge clock);
    ballX = 8'd10; ballY = 7'd20; colourIn = 3'b110; start = 1'b1;
    nextCycle();
    start = 1'b0;
    repeat (7) nextCycle();
    check("preReset.busy", 32'(busy), 1);
    #2 resetn = 1'b0;
    #1 checkAllZero("asyncReset");
    nextCycle();
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      check("postReset.done", 32'(done), 0);
      check("postReset.busy", 32'(busy), 0);
    end
    runSprite(10, 20, 3'b101, 0);

    // start held high: back-to-back sprites every 18 cycles
    @(negedge clock);
    ballX = 8'd30; ballY = 7'd40; colourIn = 3'b010; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      nextCycle();
      ph = (c - 1) % 18;
      check("held.busy", 32'(busy), (ph < 16) ? 1 : 0);
      check("held.done", 32'(done), (ph == 16) ? 1 : 0);
      check("held.plot", 32'(plot), (ph < 16) ? 1 : 0);
      if (ph < 16) check("held.drawX", 32'(drawX), 30 + ph % 4);
    end
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      nextCycle();
      if (done) seen = 1'b1;
    end
    check("held.finalDone", 32'(seen), 1);
    nextCycle();
    check("held.idle", 32'(busy), 0);

    // SIZE=1 instance
    @(negedge clock);
    ballX1 = 8'd0; ballY1 = 7'd0; colourIn1 = 3'b101; start1 = 1'b1;
    nextCycle();
    start1 = 1'b0;
    check("s1.plot", 32'(plot1), 1);
    check("s1.busy", 32'(busy1), 1);
    check("s1.drawX", 32'(drawX1), 0);
    check("s1.drawY", 32'(drawY1), 0);
    check("s1.colour", 32'(colour1), 5);
    check("s1.done1", 32'(done1), 0);
    nextCycle();
    check("s1.done2", 32'(done1), 1);
    check("s1.plot2", 32'(plot1), 0);
    check("s1.busy2", 32'(busy1), 0);
    nextCycle();
    check("s1.done3", 32'(done1), 0);

    // Randomised sprites, including off-screen and wrapping corners
    for (int i = 0; i < 8; i++) begin
      runSprite(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 16)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/draw_ball.md
DRAW_BALL -- requirements
Module: draw_ball

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, giving the side length in pixels of the square ball sprite (legal range 1..8).
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port resetn, input, 1, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to draw one sprite.
REQ-005 The block SHALL have port ballX, input, 8, the sprite top-left column (0..159 visible).
REQ-006 The block SHALL have port ballY, input, 7, the sprite top-left row (0..119 visible).
REQ-007 The block SHALL have port colourIn, input, 3, the sprite RGB colour.
REQ-008 The block SHALL have port drawX, output, 8, the current pixel column.
REQ-009 The block SHALL have port drawY, output, 7, the current pixel row.
REQ-010 The block SHALL have port colour, output, 3, the current pixel colour.
REQ-011 The block SHALL have port plot, output, 1, a write-enable to the VGA adapter for the current pixel.
REQ-012 The block SHALL have port busy, output, 1, which is high while a sprite is being drawn.
REQ-013 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, DRAW and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch ballX, ballY and colourIn into base registers, clear dx and dy to 0, and enter DRAW.
REQ-016 In DRAW, drawX SHALL equal baseX+dx (low 8 bits), drawY SHALL equal baseY+dy (low 7 bits), colour SHALL equal the latched colour, and busy SHALL be 1.
REQ-017 Each DRAW cycle, dx SHALL increment; at dx=SIZE-1, dx SHALL wrap to 0 and dy SHALL increment, so the scan is row-major, left to right and top to bottom.
REQ-018 At dx=SIZE-1 and dy=SIZE-1, the FSM SHALL go to DONE after that pixel, giving exactly SIZE*SIZE DRAW cycles.
REQ-019 Clipping: plot SHALL be 1 in DRAW only if the 9-bit sum baseX+dx <= 159 and the 8-bit sum baseY+dy <= 119; otherwise plot SHALL be 0 while the counters still advance, so the cycle count is fixed.
REQ-020 In DONE, done SHALL be 1 and busy SHALL be 0 for one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-021 Latency: with start sampled at edge N, DRAW SHALL span cycles N+1..N+SIZE*SIZE and done SHALL be high in cycle N+SIZE*SIZE+1.
REQ-022 start SHALL be ignored in DRAW and DONE, and changes to ballX, ballY or colourIn after the latch SHALL NOT affect the sprite in progress.
REQ-023 If start is held high, a new draw SHALL begin at the edge that ends the IDLE cycle following DONE, giving a period of SIZE*SIZE+2 cycles.
REQ-024 In IDLE and DONE, plot SHALL be 0 and drawX, drawY and colour SHALL hold their last values.

Reset
REQ-025 When resetn=0, the block SHALL immediately, without waiting for a clock edge, force state to IDLE; drawX, drawY, colour, dx, dy and the base registers to 0; and plot, busy and done to 0.
REQ-026 Reset asserted mid-DRAW SHALL abort the sprite with no done pulse, and the first start after resetn rises SHALL draw normally.

Verification
REQ-027 The bench SHALL check: SIZE=4, ballX=10, ballY=20, colourIn=3'b100, start pulse -> 16 plot cycles (10,20),(11,20),(12,20),(13,20),(10,21)…(13,23), colour=100 throughout, done high in cycle 17 only.
REQ-028 The bench SHALL check: a start pulse and ballX=50 applied in DRAW cycle 5 -> no restart and coordinates unchanged, with done still in cycle 17.
REQ-029 The bench SHALL check: ballX=158, ballY=118 -> plot high only at (158,118),(159,118),(158,119),(159,119) (4 of 16 cycles), with done in cycle 17.
REQ-030 The bench SHALL check: resetn low asynchronously in DRAW cycle 8 -> all outputs 0 before the next edge, no done, and a following start draws a full sprite.
REQ-031 The bench SHALL check: start held high for 40 cycles -> done pulses at cycles 17 and 35, and plot is low in cycles 17, 18 and 35.
REQ-032 The bench SHALL check: SIZE=1, ballX=0, ballY=0 -> a single plot at (0,0) in cycle 1 and done in cycle 2.
